// File: rtl/pen_ram_writer_pkg.sv
// Shared definitions for the light-pen write path: matrix geometry, pixel code
// bit positions and one-hot <-> index helpers.
package pen_ram_writer_pkg;

    localparam int unsigned MATRIX_N  = 8;
    localparam int unsigned LIT_BIT   = 3;
    localparam int unsigned GREEN_BIT = 2;
    localparam int unsigned RED_BIT   = 1;

    typedef logic [2:0]          idx_t;
    typedef logic [MATRIX_N-1:0] onehot_t;

    typedef struct packed {
        logic valid;
        idx_t y;
        idx_t x;
    } pos_t;

    function automatic logic is_onehot(input onehot_t v);
        return (v != '0) && ((v & (v - onehot_t'(1))) == '0);
    endfunction

    function automatic idx_t onehot_to_idx(input onehot_t v);
        idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < MATRIX_N; i++) begin
            if (v[i]) begin
                idx = idx | idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic onehot_t idx_to_onehot(input idx_t i);
        return onehot_t'(1) << i;
    endfunction

    function automatic pos_t encode_pos(input onehot_t row, input onehot_t col);
        pos_t p;
        p.valid = is_onehot(row) && is_onehot(col);
        p.y     = onehot_to_idx(row);
        p.x     = onehot_to_idx(col);
        return p;
    endfunction

endpackage

// File: rtl/pen_ram_writer_if.sv
// Write port into the LED display RAM; the writer drives it, led_ram consumes it.
interface pen_ram_writer_if;
    import pen_ram_writer_pkg::*;

    logic       ram_we;
    onehot_t    ram_addr_row;
    onehot_t    ram_addr_col;
    logic [3:0] ram_wdata;

    modport master (output ram_we, ram_addr_row, ram_addr_col, ram_wdata);
    modport slave  (input  ram_we, ram_addr_row, ram_addr_col, ram_wdata);

endinterface

// File: rtl/pen_ram_writer_pen_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector; the
// pulse appears three cycles after the asynchronous input rises.
module pen_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            sync       <= 1'b0;
            sync_d     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            meta       <= async_in;
            sync       <= meta;
            sync_d     <= sync;
            rise_pulse <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/pen_ram_writer.sv
// Turns confirmed light-pen hits into single pixel writes on the LED RAM port,
// and sequences a full-screen clear on request.
module pen_ram_writer
    import pen_ram_writer_pkg::*;
#(
    parameter int unsigned PEN_LAG      = 2,
    parameter int unsigned CONFIRM_HITS = 2,
    parameter int unsigned FRAME_LEN    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        scan_row,
    input  logic [7:0]        scan_col,
    input  logic              pen_in,
    input  logic [1:0]        color_sel,
    input  logic              clear_req,
    pen_ram_writer_if.master  ram,
    output logic              busy,
    output logic              pen_valid,
    output logic [2:0]        pen_x,
    output logic [2:0]        pen_y
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_CLEAR   = 2'd3;

    localparam int unsigned DLY_DEPTH   = PEN_LAG + 3;
    localparam logic [2:0]  CONFIRM_TGT = 3'(CONFIRM_HITS);
    localparam logic [5:0]  CLR_LAST    = 6'(FRAME_LEN - 1);

    function automatic logic at_origin(input pos_t p);
        return p.valid && (p.y == '0) && (p.x == '0);
    endfunction

    logic [1:0] state;
    idx_t       cand_y;
    idx_t       cand_x;
    logic [2:0] count;
    logic       frame_hit;
    logic [5:0] clr_cnt;

    pos_t pos_now;
    pos_t pos_prev;
    pos_t pos_lag;
    pos_t dly [DLY_DEPTH];

    logic pen_rise;
    logic hit_ok;
    logic frame_edge;
    logic chain_alive;
    logic cand_match;
    logic [2:0] count_next;

    pen_sync_edge u_pen_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (pen_in),
        .rise_pulse (pen_rise)
    );

    assign pos_now = encode_pos(scan_row, scan_col);
    assign pos_lag = dly[DLY_DEPTH-1];

    // Delay depth covers the pen lag plus the three cycles of sync/edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_prev <= '0;
            for (int unsigned i = 0; i < DLY_DEPTH; i++) begin
                dly[i] <= '0;
            end
        end else begin
            pos_prev <= pos_now;
            dly[0]   <= pos_now;
            for (int unsigned i = 1; i < DLY_DEPTH; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign hit_ok      = pen_rise && pos_lag.valid;
    assign frame_edge  = at_origin(pos_now) && !at_origin(pos_prev);
    assign chain_alive = !(frame_edge && !frame_hit);
    assign cand_match  = (pos_lag.y == cand_y) && (pos_lag.x == cand_x);
    assign count_next  = count + 3'd1;

    // clear_req overrides everything; a WRITE in progress has already driven its
    // outputs this cycle, so taking CLEAR next still issues that write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cand_y    <= '0;
            cand_x    <= '0;
            count     <= '0;
            frame_hit <= 1'b0;
            clr_cnt   <= '0;
            pen_x     <= '0;
            pen_y     <= '0;
        end else if (clear_req) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            count     <= '0;
            frame_hit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit_ok) begin
                        cand_y    <= pos_lag.y;
                        cand_x    <= pos_lag.x;
                        count     <= 3'd1;
                        frame_hit <= 1'b1;
                        if (CONFIRM_HITS == 1) begin
                            state <= ST_WRITE;
                            pen_x <= pos_lag.x;
                            pen_y <= pos_lag.y;
                        end else begin
                            state <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (frame_edge && !frame_hit && !hit_ok) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else if (hit_ok && (frame_edge || !frame_hit)) begin
                        // A hit on the first cycle of a frame that followed an
                        // empty frame starts a fresh chain rather than extending.
                        frame_hit <= 1'b1;
                        if (cand_match && chain_alive) begin
                            count <= count_next;
                            if (count_next == CONFIRM_TGT) begin
                                state <= ST_WRITE;
                                pen_x <= cand_x;
                                pen_y <= cand_y;
                            end
                        end else begin
                            cand_y <= pos_lag.y;
                            cand_x <= pos_lag.x;
                            count  <= 3'd1;
                        end
                    end else if (frame_edge) begin
                        frame_hit <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    state     <= ST_IDLE;
                    count     <= '0;
                    frame_hit <= 1'b0;
                end
                default: begin
                    if (clr_cnt == CLR_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 6'd1;
                    end
                end
            endcase
        end
    end

    logic       we;
    onehot_t    addr_row;
    onehot_t    addr_col;
    logic [3:0] wdata;

    always_comb begin
        we       = 1'b0;
        addr_row = '0;
        addr_col = '0;
        wdata    = '0;
        case (state)
            ST_WRITE: begin
                we               = 1'b1;
                addr_row         = idx_to_onehot(cand_y);
                addr_col         = idx_to_onehot(cand_x);
                wdata[LIT_BIT]   = 1'b1;
                wdata[GREEN_BIT] = color_sel[1];
                wdata[RED_BIT]   = color_sel[0];
            end
            ST_CLEAR: begin
                we       = 1'b1;
                addr_row = idx_to_onehot(clr_cnt[5:3]);
                addr_col = idx_to_onehot(clr_cnt[2:0]);
            end
            default: begin
            end
        endcase
    end

    assign ram.ram_we       = we;
    assign ram.ram_addr_row = addr_row;
    assign ram.ram_addr_col = addr_col;
    assign ram.ram_wdata    = wdata;

    assign busy      = (state == ST_WRITE) || (state == ST_CLEAR);
    assign pen_valid = (state == ST_WRITE);

endmodule

// File: tb/tb_pen_ram_writer.sv
// Scoreboard bench for pen_ram_writer: directed scan/pen frames push expected
// RAM writes; a negedge monitor pops and compares every write it sees.
module tb_pen_ram_writer;
    import pen_ram_writer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scan_row = '0;
    logic [7:0] scan_col = '0;
    logic       pen_in = 1'b0;
    logic [1:0] color_sel = '0;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       pen_valid;
    logic [2:0] pen_x;
    logic [2:0] pen_y;

    pen_ram_writer_if ram ();

    pen_ram_writer #(
        .PEN_LAG      (2),
        .CONFIRM_HITS (2),
        .FRAME_LEN    (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_row  (scan_row),
        .scan_col  (scan_col),
        .pen_in    (pen_in),
        .color_sel (color_sel),
        .clear_req (clear_req),
        .ram       (ram),
        .busy      (busy),
        .pen_valid (pen_valid),
        .pen_x     (pen_x),
        .pen_y     (pen_y)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [3:0]  wd;
        logic        pv;
        logic [2:0]  px;
        logic [2:0]  py;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk_w(input logic [7:0] r, input logic [7:0] c,
                                  input logic [3:0] wd, input logic [2:0] x,
                                  input logic [2:0] y);
        exp_t e;
        e.cyc = 0; e.row = r; e.col = c; e.wd = wd; e.pv = 1'b1; e.px = x; e.py = y;
        return e;
    endfunction

    function automatic exp_t no_w();
        exp_t e;
        e.cyc = 0; e.row = '0; e.col = '0; e.wd = '0; e.pv = 1'b0; e.px = '0; e.py = '0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear(input int unsigned start, input int unsigned n);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.cyc = start + i;
            e.row = 8'h01 << (i / 8);
            e.col = 8'h01 << (i % 8);
            e.wd  = 4'b0000;
            e.pv  = 1'b0;
            e.px  = '0;
            e.py  = '0;
            exp_q.push_back(e);
        end
    endtask

    // One 64-position frame. The pen edge comes 2 cycles after the hit position
    // is scanned; an expected write lands 6 cycles after that position.
    task automatic run_frame(input int hit_pos, input exp_t ew, input bit bad_en,
                             input logic [7:0] bad_row, input logic [7:0] bad_col,
                             input int clr_pos, input int unsigned clr_n,
                             input int clr2_pos, input int unsigned clr2_n);
        exp_t e;
        for (int p = 0; p < 64; p++) begin
            scan_row = 8'h01 << (p / 8);
            scan_col = 8'h01 << (p % 8);
            if (bad_en && p == hit_pos) begin
                scan_row = bad_row;
                scan_col = bad_col;
            end
            pen_in = (hit_pos >= 0) && (p >= hit_pos + 2) && (p < hit_pos + 6);
            if (ew.pv && p == hit_pos) begin
                e = ew;
                e.cyc = cyc + 6;
                exp_q.push_back(e);
            end
            clear_req = (p == clr_pos) || (p == clr2_pos);
            if (p == clr_pos)  push_clear(cyc + 1, clr_n);
            if (p == clr2_pos) push_clear(cyc + 1, clr2_n);
            tick();
        end
        pen_in    = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic hit_frame(input int hit_pos, input exp_t ew);
        run_frame(hit_pos, ew, 1'b0, '0, '0, -1, 0, -1, 0);
    endtask

    task automatic empty_frames(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            run_frame(-1, no_w(), 1'b0, '0, '0, -1, 0, -1, 0);
        end
    endtask

    always @(negedge clk) begin
        if (ram.ram_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write cyc=%0d row=%h col=%h wdata=%b", cyc,
                         ram.ram_addr_row, ram.ram_addr_col, ram.ram_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || ram.ram_addr_row !== mon_e.row ||
                    ram.ram_addr_col !== mon_e.col || ram.ram_wdata !== mon_e.wd ||
                    pen_valid !== mon_e.pv || busy !== 1'b1 ||
                    (mon_e.pv && (pen_x !== mon_e.px || pen_y !== mon_e.py))) begin
                    n_bad++;
                    $display("FAIL ram_write got cyc=%0d row=%h col=%h wd=%b pv=%b busy=%b x=%0d y=%0d need cyc=%0d row=%h col=%h wd=%b pv=%b busy=1 x=%0d y=%0d",
                             cyc, ram.ram_addr_row, ram.ram_addr_col, ram.ram_wdata,
                             pen_valid, busy, pen_x, pen_y, mon_e.cyc, mon_e.row,
                             mon_e.col, mon_e.wd, mon_e.pv, mon_e.px, mon_e.py);
                end
            end
        end else if (rst_n) begin
            n_cmp++;
            if (busy !== 1'b0 || pen_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_outputs cyc=%0d got busy=%b pen_valid=%b need 0 0",
                         cyc, busy, pen_valid);
            end
        end
    end

    initial begin
        repeat (3) tick();
        n_cmp++;
        if ({ram.ram_we, ram.ram_addr_row, ram.ram_addr_col, ram.ram_wdata,
             busy, pen_valid, pen_x, pen_y} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got we=%b row=%h col=%h wd=%b busy=%b pv=%b x=%0d y=%0d need all 0",
                     ram.ram_we, ram.ram_addr_row, ram.ram_addr_col, ram.ram_wdata,
                     busy, pen_valid, pen_x, pen_y);
        end
        rst_n = 1'b1;
        tick();

        // idle scanning, no pen
        empty_frames(1);

        // (3,5) confirmed over two frames, red
        color_sel = 2'b01;
        hit_frame(29, no_w());
        hit_frame(29, mk_w(8'h08, 8'h20, 4'b1010, 3'd5, 3'd3));
        empty_frames(2);

        // candidate replaced by (4,5), confirmed in frame 3, green
        color_sel = 2'b10;
        hit_frame(29, no_w());
        hit_frame(37, no_w());
        hit_frame(37, mk_w(8'h10, 8'h20, 4'b1100, 3'd5, 3'd4));
        empty_frames(2);

        // gap frame drops the chain; frames 3 and 4 confirm (6,2), yellow
        color_sel = 2'b11;
        hit_frame(50, no_w());
        empty_frames(1);
        hit_frame(50, no_w());
        hit_frame(50, mk_w(8'h40, 8'h04, 4'b1110, 3'd2, 3'd6));
        empty_frames(2);

        // hits on an invalid scan position are ignored
        run_frame(29, no_w(), 1'b1, 8'h00, 8'h20, -1, 0, -1, 0);
        run_frame(29, no_w(), 1'b1, 8'h00, 8'h20, -1, 0, -1, 0);
        run_frame(29, no_w(), 1'b1, 8'h28, 8'h20, -1, 0, -1, 0);
        run_frame(29, no_w(), 1'b1, 8'h28, 8'h20, -1, 0, -1, 0);
        empty_frames(2);

        // clear, restarted after 21 writes; pen hits during clear are dropped
        run_frame(12, no_w(), 1'b0, '0, '0, 1, 21, 22, 64);
        hit_frame(12, no_w());
        empty_frames(2);

        // clear_req coinciding with the WRITE cycle
        color_sel = 2'b01;
        hit_frame(29, no_w());
        run_frame(29, mk_w(8'h08, 8'h20, 4'b1010, 3'd5, 3'd3), 1'b0, '0, '0, 35, 64, -1, 0);
        empty_frames(2);

        // async reset in the middle of a clear
        for (int p = 0; p < 5; p++) begin
            scan_row = 8'h01;
            scan_col = 8'h01 << p;
            tick();
        end
        clear_req = 1'b1;
        push_clear(cyc + 1, 12);
        tick();
        clear_req = 1'b0;
        repeat (12) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ram.ram_we, ram.ram_addr_row, ram.ram_addr_col, ram.ram_wdata,
             busy, pen_valid, pen_x, pen_y} !== '0) begin
            n_bad++;
            $display("FAIL reset_abort got we=%b row=%h col=%h wd=%b busy=%b pv=%b x=%0d y=%0d need all 0",
                     ram.ram_we, ram.ram_addr_row, ram.ram_addr_col, ram.ram_wdata,
                     busy, pen_valid, pen_x, pen_y);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        empty_frames(1);

        repeat (4) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_writes got %0d outstanding need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pen_ram_writer.md
Name: pen_ram_writer

Overview:
- Write-side counterpart of the LED matrix display path: turns light-pen hits into pixel writes to the LED display RAM (led_ram write port).
- Correlates the synchronised pen photodiode pulse with the current scan position (one-hot row/col from scan_driver), delayed by the pen response lag.
- Confirms a hit over consecutive frames, then writes the pixel code. Also provides a full-screen clear sequencer.
- Sits between scan_driver/pen input and led_ram; replaces the tied-off we/data on the display RAM.

Parameters:
- PEN_LAG, 2, cycles between scan position presentation and pen pulse edge; range 0..15.
- CONFIRM_HITS, 2, consecutive frames that must report the same position before a write; range 1..7.
- FRAME_LEN, 64, scan positions per frame; frame boundary = scan position wraps to (0,0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_row  in  8  one-hot current scan row (from scan_driver)
- scan_col  in  8  one-hot current scan column
- pen_in  in  1  raw asynchronous pen photodiode, active high
- color_sel  in  2  bit0=red, bit1=green for written pixels
- clear_req  in  1  single-cycle pulse: clear entire RAM
- ram_we  out  1  RAM write enable, one cycle per write
- ram_addr_row  out  8  one-hot RAM row address
- ram_addr_col  out  8  one-hot RAM column address
- ram_wdata  out  4  pixel code {lit, green, red, 0}
- busy  out  1  high during WRITE or CLEAR
- pen_valid  out  1  one-cycle pulse when a confirmed write is issued
- pen_x  out  3  column index of last confirmed hit
- pen_y  out  3  row index of last confirmed hit

Behaviour:
- Reset: all outputs 0; FSM=IDLE; sync flops, lag line, confirm counter cleared.
- pen_in passes a 2-flop synchroniser, then a rising-edge detector (hit pulse = 3 cycles after pin edge).
- Scan position encoded each cycle to {y,x} (3+3 bits) plus valid = exactly one bit set in both scan_row and scan_col. Stored in a PEN_LAG+3 deep delay line so the hit pulse aligns with the position lit PEN_LAG cycles before the raw edge.
- Hit with invalid delayed position: ignored.
- Frame boundary: undelayed position changes to (0,0) from any other value.
- FSM states:
  - IDLE: hit -> store candidate {y,x}, count=1, go to CONFIRM. If CONFIRM_HITS=1, go directly to WRITE.
  - CONFIRM: per frame at most one hit is counted. Hit at candidate position -> count+1; hit at other position -> replace candidate, count=1. Frame boundary with no hit in the just-ended frame -> IDLE. count==CONFIRM_HITS -> WRITE.
  - WRITE: one cycle. ram_we=1, addresses = one-hot of candidate, ram_wdata={1,color_sel[1],color_sel[0],0}, pen_valid=1, pen_x/pen_y updated. Next state IDLE.
  - CLEAR: 64 cycles. ram_we=1 each cycle, addresses walk row-major from (0,0) to (7,7), ram_wdata=0000. Next state IDLE; confirm state cleared.
- clear_req priority: accepted in any state, including mid-CONFIRM or the WRITE cycle. A WRITE coinciding with clear_req is still issued, then CLEAR starts next cycle. clear_req during CLEAR restarts the walk at (0,0).
- Hits arriving during WRITE/CLEAR are dropped.
- busy = (state==WRITE) or (state==CLEAR). ram_we is never asserted outside WRITE/CLEAR.
- Latency: raw pen edge of the confirming frame -> ram_we = 4 cycles (3 sync/edge + 1 state).
- Async reset mid-CLEAR: abort immediately; RAM contents are not restored.

Decomposition:
- Shared package: pixel code bit positions (LIT=3, GREEN=2, RED=1), one-hot<->index conversion functions, matrix size constant 8.
- Sub-module: pen_sync_edge (2-flop synchroniser + rising-edge detector), reused for other async inputs.

Test Plan:
- Reset then idle scan, pen_in=0 -> ram_we never asserted; all outputs 0.
- PEN_LAG=2, CONFIRM_HITS=2, color_sel=01: pen edge 2 cycles after scan (row3,col5) in two consecutive frames -> one ram_we with row=0x08, col=0x20, wdata=0b1010; pen_x=5, pen_y=3; pen_valid for 1 cycle.
- Hit at (3,5) in frame 1, then at (4,5) in frame 2 -> no write; hit at (4,5) in frame 3 -> write at (4,5).
- Hit in frame 1, no hit in frame 2, hit in frame 3 -> no write until frame 4 confirms.
- clear_req pulse -> 64 consecutive ram_we cycles covering all (row,col) once with wdata=0, busy high 64 cycles; pen hits during this time are ignored.
- Scan input 0x00 or two bits set at the time of a hit -> hit ignored; async reset asserted during CLEAR -> ram_we=0 in the same cycle.
